ifetch_stage: RTL
=================

# ifetch_stage

Instruction fetch stage placed directly upstream of the instruction cache. It owns the program counter, drives the cache read address every cycle, pairs each returned instruction with its PC, and presents `{pc, instr}` to decode through a registered valid/stall interface. It supports decode back-pressure through a one-entry skid buffer, and a branch/jump redirect from execute that flushes everything in flight.

## Interface
- `RESET_PC`, default `32'h0000_0004`: first fetch address after reset.
- `PC_STEP`, default `4`: sequential PC increment, in bytes.

- `clk` in 1: rising-edge clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `stall` in 1: decode cannot accept a new instruction this cycle.
- `redirect_valid` in 1: execute requests a control-flow change.
- `redirect_pc` in 32: redirect target; bits [1:0] are ignored and forced to 0.
- `iaddr` out 32: read address to the instruction cache; equals `fetch_pc` combinationally.
- `icache_instr` in 32: cache read data for the `iaddr` value sampled at the previous rising edge.
- `if_valid` out 1: `if_pc` and `if_instr` hold a valid instruction.
- `if_pc` out 32: PC of the presented instruction.
- `if_instr` out 32: presented instruction word.

## Operation
- State registers:
  - `fetch_pc`: address currently driven on `iaddr`.
  - `resp_valid`/`resp_pc`: request issued last cycle; its data is on `icache_instr` now.
  - `skid_valid`/`skid_pc`/`skid_instr`: one-entry buffer.
  - `if_valid`/`if_pc`/`if_instr`: output register.
- Reset (async, `rst_n`=0):
  - `fetch_pc`=`RESET_PC`.
  - `resp_valid`, `skid_valid` and `if_valid` are 0.
  - `if_pc` and `if_instr` are 0.
  - `resp_pc` and skid contents are 0.
- `accept` = `!if_valid || !stall`, meaning the output register may load.
- Priority per cycle: redirect > accept > hold.
- Redirect (`redirect_valid`=1), regardless of `stall`:
  - `fetch_pc` <= `{redirect_pc[31:2],2'b00}`.
  - `resp_valid`, `skid_valid` and `if_valid` <= 0.
  - No issue this cycle.
- Accept:
  - Issue: `resp_valid`<=1, `resp_pc`<=`fetch_pc`, `fetch_pc`<=`fetch_pc+PC_STEP`.
  - Output load priority:
    - If `skid_valid`: load skid into the output register and clear `skid_valid`.
    - Else if `resp_valid`: load `{resp_pc, icache_instr}`.
    - Else: `if_valid`<=0.
- Hold (`if_valid`=1, `stall`=1, no redirect):
  - Output registers unchanged.
  - `fetch_pc` unchanged, and no issue: `resp_valid`<=0.
  - If `resp_valid`=1: capture `{resp_pc, icache_instr}` into the skid and set `skid_valid`<=1.
- Invariants:
  - `skid_valid` and `resp_valid` are never both 1.
  - At most one request is outstanding.
  - No instruction is dropped or duplicated except by a redirect flush.
- Arithmetic: `fetch_pc+PC_STEP` is 32-bit modulo 2^32, so `0xFFFF_FFFC` wraps to `0x0000_0000`.

## Timing
- Fetch latency: `iaddr`=A at edge k, data at edge k+1, `if_valid`/`if_pc`=A visible after edge k+2.
- After `rst_n` deasserts:
  - First issue at the first edge.
  - `if_valid`=1 with `if_pc`=`RESET_PC` after the second edge.
- Redirect sampled at edge E:
  - `iaddr`=target after E.
  - `if_valid`=0 after E and E+1.
  - `if_valid`=1 with `if_pc`=target after E+2.
- Throughput: one instruction per cycle while `stall`=0.
- Stall release:
  - Skid contents appear after the first edge with `stall`=0.
  - The next sequential instruction appears the following edge, with no bubble.
- `stall` while `if_valid`=0 is ignored: the output loads normally.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge.

## Test plan
- Reset, no stall, cache preloaded: `if_pc` = 0x4, 0x8, 0xC, … on consecutive cycles, each `if_instr` matching the preloaded word, first valid 2 edges after reset release.
- `stall`=1 for 3 cycles while `if_pc`=0x8:
  - `if_pc`/`if_instr` are held at 0x8.
  - `iaddr` is frozen.
  - After release, the sequence resumes at 0xC then 0x10, with no gap and no repeat.
- `redirect_valid`=1 with `redirect_pc`=0x28, during `stall`=1 and with the skid full:
  - Skid and output are flushed; `if_valid`=0 for 2 cycles.
  - The sequence then resumes 0x28, 0x2C.
- `redirect_pc`=0x37 (misaligned): `iaddr`=0x34 and `if_pc`=0x34.
- Redirect to 0xFFFF_FFFC: `if_pc` sequence 0xFFFF_FFFC, then 0x0000_0000.
- Assert `rst_n`=0 mid-stream between clock edges:
  - All `if_*` outputs go to 0 immediately; `iaddr`=`RESET_PC`.
  - Normal restart after release.

Source files
------------

// File: rtl/ifetch_stage.sv
// Instruction fetch stage: owns the PC, drives the I-cache address every
// cycle, pairs each returned word with its PC and presents {pc, instr} to
// decode through a registered valid/stall interface. A one-entry skid buffer
// absorbs the in-flight response when decode stalls. A redirect from execute
// flushes everything in flight.
module ifetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0004,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] iaddr,
    input  logic [31:0] icache_instr,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
);

    // Source for the output register when it is allowed to load.
    typedef enum logic [1:0] {
        LOAD_NONE,
        LOAD_SKID,
        LOAD_RESP
    } load_src_e;

    logic [31:0] fetch_pc;
    logic        resp_valid;
    logic [31:0] resp_pc;
    logic        skid_valid;
    logic [31:0] skid_pc;
    logic [31:0] skid_instr;

    logic        accept;
    logic [31:0] redirect_target;
    load_src_e   load_src;

    // The output register may load when it is empty or decode takes it.
    assign accept          = !if_valid || !stall;
    // Targets are word aligned; the low two bits are dropped.
    assign redirect_target = redirect_pc & ~32'h0000_0003;
    assign iaddr           = fetch_pc;

    // Pick what the output register loads: skid first (it is older), then the
    // response arriving from the cache this cycle.
    always_comb begin
        // NOTE: default assignment first so no path leaves load_src unassigned,
        // which would otherwise infer a latch.
        load_src = LOAD_NONE;
        if (skid_valid) begin
            load_src = LOAD_SKID;
        end else if (resp_valid) begin
            load_src = LOAD_RESP;
        end
    end

    // Program counter and the single outstanding cache request.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values, independent of statement order.
        if (!rst_n) begin
            fetch_pc   <= RESET_PC;
            resp_valid <= 1'b0;
            resp_pc    <= 32'h0;
        end else if (redirect_valid) begin
            fetch_pc   <= redirect_target;
            resp_valid <= 1'b0;
        end else if (accept) begin
            resp_valid <= 1'b1;
            resp_pc    <= fetch_pc;
            fetch_pc   <= fetch_pc + PC_STEP;
        end else begin
            // Holding: no new request, so nothing is outstanding next cycle.
            resp_valid <= 1'b0;
        end
    end

    // Skid buffer: catches the response that lands while decode is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the skid payload is reset as well so its contents are defined
        // from the first cycle rather than left as X until first capture.
        if (!rst_n) begin
            skid_valid <= 1'b0;
            skid_pc    <= 32'h0;
            skid_instr <= 32'h0;
        end else if (redirect_valid) begin
            skid_valid <= 1'b0;
        end else if (accept) begin
            // Either drained into the output register now, or already empty.
            skid_valid <= 1'b0;
        end else if (resp_valid) begin
            skid_valid <= 1'b1;
            skid_pc    <= resp_pc;
            skid_instr <= icache_instr;
        end
    end

    // Output register presented to decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_valid <= 1'b0;
            if_pc    <= 32'h0;
            if_instr <= 32'h0;
        end else if (redirect_valid) begin
            if_valid <= 1'b0;
        end else if (accept) begin
            case (load_src)
                LOAD_SKID: begin
                    if_valid <= 1'b1;
                    if_pc    <= skid_pc;
                    if_instr <= skid_instr;
                end
                LOAD_RESP: begin
                    if_valid <= 1'b1;
                    if_pc    <= resp_pc;
                    if_instr <= icache_instr;
                end
                default: begin
                    if_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
